cbus_axi_bridge: RTL and testbench
==================================

CBUS_AXI_BRIDGE -- requirements
Module: cbus_axi_bridge

Interface
REQ-001 Parameter AXI_ID, default 4'd0: constant ID driven on arid/awid/wid; rid and bid are ignored.
REQ-002 clk  in  1  single clock; all state is updated on its rising edge.
REQ-003 resetn  in  1  reset, asynchronous and active-low.
REQ-004 creq  in  cbus_req_t  cache-side request {valid, is_write, size, addr, strobe, data, len}.
REQ-005 cresp  out  cbus_resp_t  cache-side response {ready, last, data}.
REQ-006 AR group  out  arvalid 1, araddr 32, arlen 4, arsize 3, arburst 2; arready in 1.
REQ-007 R group  in  rvalid 1, rdata 32, rresp 2, rlast 1; rready out 1.
REQ-008 AW group  out  awvalid 1, awaddr 32, awlen 4, awsize 3, awburst 2; awready in 1.
REQ-009 W group  out  wvalid 1, wdata 32, wstrb 4, wlast 1; wready in 1.
REQ-010 B group  in  bvalid 1, bresp 2; bready out 1.

Function
REQ-011 The FSM SHALL have these states: IDLE, AR, R, AW, W, B.
REQ-012 In IDLE with creq.valid=1, the bridge SHALL latch creq.addr/size/len/is_write and go to AW if is_write=1, otherwise to AR.
REQ-013 arvalid/awvalid SHALL be registered and assert the cycle after the request is latched: 1-cycle request-to-address latency.
REQ-014 Address channel mapping SHALL be: ax_addr = latched addr; ax_len = latched len (MLEN1=0 ... MLEN16=15); ax_size = latched size; ax_burst = 2'b01 (INCR).
REQ-015 AR/AW valid SHALL hold until the ready handshake. Then AR goes to R and AW goes to W.
REQ-016 In R, rready=1, and each cycle rvalid=1 SHALL produce cresp.ready=1 and cresp.data=rdata combinationally.
REQ-017 In R, cresp.last SHALL equal rvalid&rlast; on that beat the FSM goes to IDLE.
REQ-018 In W, wvalid=1, wdata=creq.data, wstrb=creq.strobe (live, not latched), and a 4-bit beat counter starts at 0.
REQ-019 wlast SHALL be 1 when the beat counter equals the latched len.
REQ-020 Each non-final W handshake SHALL assert cresp.ready=1 and increment the counter, so the cache advances its data.
REQ-021 The final W handshake SHALL NOT assert cresp.ready; the FSM goes to B.
REQ-022 In B, bready=1; on bvalid the bridge SHALL assert cresp.ready=1 and cresp.last=1 for one cycle and go to IDLE.
REQ-023 rresp and bresp SHALL be ignored; error responses complete the transaction normally.
REQ-024 cresp.data SHALL be 0 outside R-state beats.
REQ-025 cresp.ready and cresp.last SHALL be 0 in IDLE, AR and AW.
REQ-026 The bridge SHALL NOT sample creq in the cycle cresp.last=1.
REQ-027 A back-to-back creq.valid (e.g. write-back followed by refill) SHALL be latched in IDLE the cycle after last, with no idle bubble beyond that.
REQ-028 Changes to creq fields other than data/strobe during a transaction are illegal; the verification bench SHALL flag them with an assertion, and the design need not handle them.
REQ-029 Only one AXI transaction SHALL be outstanding at a time; AR and AW are never both valid.

Reset
REQ-030 On resetn=0, immediately and without waiting for clk: state=IDLE, beat counter=0, latched fields=0, all AXI valid/ready/last outputs=0, cresp=0.
REQ-031 Reset mid-burst SHALL abandon the transaction with no further beats. After resetn=1, the first clk edge SHALL be able to accept a new request.

Verification
REQ-032 Single read (MLEN1, MSIZE4, addr 0x1000_0004; arready=1, rvalid+rlast with 0xDEADBEEF) -> arvalid the cycle after valid, araddr=0x1000_0004, arlen=0; one cycle of cresp.ready=1, last=1, data=0xDEADBEEF; back to IDLE.
REQ-033 4-beat refill (MLEN4 at 0x8000_0040; rvalid gaps of 1 cycle) -> arlen=3, arburst=01; exactly 4 cresp.ready pulses, last only on the 4th; data order matches rdata.
REQ-034 4-beat write-back (wready toggling 1/0, bvalid 3 cycles after wlast) -> awlen=3; wlast only on beat 3; 3 ready pulses during W; ready+last only with bvalid; wstrb=creq.strobe.
REQ-035 Write-back then refill with creq.valid held continuously -> AW burst completes, then AR issues 2 cycles after B handshake (IDLE latch + registered arvalid); no duplicate AW.
REQ-036 resetn pulsed low during beat 2 of a 4-beat read -> all outputs 0 asynchronously; after release a new MLEN1 read completes normally.
REQ-037 Stall (arready=0 for 10 cycles) -> arvalid and araddr stable throughout; cresp.ready=0 throughout.

Source files
------------

// File: rtl/cbus_axi_bridge.sv
// Cache-bus to AXI bridge: one outstanding INCR burst at a time, reads via AR/R, writes via AW/W/B.
// Address/len/size are latched in IDLE; write data and strobes are passed through live from the cache.
module cbus_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        creq_valid,
    input  logic        creq_is_write,
    input  logic [2:0]  creq_size,
    input  logic [31:0] creq_addr,
    input  logic [3:0]  creq_strobe,
    input  logic [31:0] creq_data,
    input  logic [3:0]  creq_len,
    output logic        cresp_ready,
    output logic        cresp_last,
    output logic [31:0] cresp_data,
    output logic [3:0]  arid,
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic        rready,
    output logic [3:0]  awid,
    output logic        awvalid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic        wvalid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  beat_q, beat_d;
    logic        arvalid_q, arvalid_d;
    logic        awvalid_q, awvalid_d;
    logic        rready_q, rready_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        beat_last;
    logic        unused_inputs;

    // Response IDs and error codes carry no information for the cache side.
    assign unused_inputs = ^{rid, bid, rresp, bresp};

    assign beat_last = (beat_q == len_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        beat_d    = beat_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        rready_d  = rready_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        unique case (state_q)
            ST_IDLE: begin
                if (creq_valid) begin
                    addr_d = creq_addr;
                    len_d  = creq_len;
                    size_d = creq_size;
                    beat_d = '0;
                    if (creq_is_write) begin
                        state_d   = ST_AW;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d   = ST_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_d   = ST_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_R: begin
                if (rvalid && rlast) begin
                    state_d  = ST_IDLE;
                    rready_d = 1'b0;
                end
            end
            ST_AW: begin
                if (awready) begin
                    state_d   = ST_W;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    beat_d    = '0;
                end
            end
            ST_W: begin
                if (wready) begin
                    if (beat_last) begin
                        state_d  = ST_B;
                        wvalid_d = 1'b0;
                        bready_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            ST_B: begin
                if (bvalid) begin
                    state_d  = ST_IDLE;
                    bready_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            beat_q    <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            beat_q    <= beat_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            rready_q  <= rready_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    // The final W beat is acknowledged to the cache only with the B response.
    always_comb begin
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        cresp_data  = '0;
        if (state_q == ST_R && rvalid) begin
            cresp_ready = 1'b1;
            cresp_last  = rlast;
            cresp_data  = rdata;
        end
        if (state_q == ST_W && wvalid_q && wready && !beat_last) begin
            cresp_ready = 1'b1;
        end
        if (state_q == ST_B && bvalid) begin
            cresp_ready = 1'b1;
            cresp_last  = 1'b1;
        end
    end

    assign arid    = AXI_ID;
    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = 2'b01;
    assign rready  = rready_q;

    assign awid    = AXI_ID;
    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = size_q;
    assign awburst = 2'b01;

    assign wid     = AXI_ID;
    assign wvalid  = wvalid_q;
    assign wdata   = wvalid_q ? creq_data : '0;
    assign wstrb   = wvalid_q ? creq_strobe : '0;
    assign wlast   = wvalid_q && beat_last;
    assign bready  = bready_q;

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Bench for cbus_axi_bridge: a cache master plus AXI slave driver, scored per transaction
// against the expected burst shape (beat count, order, last position, address fields).
module tb_cbus_axi_bridge;

    localparam logic [3:0] ID = 4'd5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        creq_valid, creq_is_write;
    logic [2:0]  creq_size;
    logic [31:0] creq_addr, creq_data;
    logic [3:0]  creq_strobe, creq_len;
    logic        cresp_ready, cresp_last;
    logic [31:0] cresp_data;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;

    cbus_axi_bridge #(.AXI_ID(ID)) dut (
        .clk(clk), .resetn(resetn),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
        .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
        .creq_len(creq_len),
        .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
        .arid(arid), .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arready(arready),
        .rid(rid), .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready),
        .awid(awid), .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awready(awready),
        .wid(wid), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bresp(bresp), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Request fields other than data/strobe must not move while a transaction is in flight.
    logic        busy;
    logic        busy_prev = 1'b0;
    logic [39:0] fields, fields_prev;
    assign busy   = arvalid | awvalid | rready | wvalid | bready;
    assign fields = {creq_is_write, creq_size, creq_addr, creq_len};
    always @(posedge clk) begin
        if (resetn && busy && busy_prev)
            assert (fields == fields_prev) else $error("creq fields changed during a transaction");
        busy_prev   <= busy && resetn;
        fields_prev <= fields;
    end

    function automatic logic pick(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return cyc[0];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic slave_idle();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0; rid = '0;
        bvalid = 1'b0; bresp = '0; bid = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ctl"}, 32'({arvalid, awvalid, rready, wvalid, bready, wlast, cresp_ready, cresp_last}), 32'd0);
        check({tag, " cdata"}, cresp_data, 32'd0);
        check({tag, " addr"}, araddr | awaddr, 32'd0);
        check({tag, " len/size"}, 32'({arlen, awlen, arsize, awsize}), 32'd0);
        check({tag, " wdata"}, wdata, 32'd0);
    endtask

    // Runs one cache transaction from the IDLE cycle (entered at posedge+1) to its last beat.
    // mode: 0 = slave always ready, 1 = alternating handshakes, 2 = random handshakes.
    task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input int mode,
                           input int stall, input bit keep_valid, input int exp_beats);
        logic [31:0] data_q[$];
        logic [3:0]  strb_q[$];
        logic [31:0] got_q[$];
        logic [31:0] wd_q[$];
        logic [3:0]  ws_q[$];
        int n_beats = int'(len) + 1;
        int first_v = -1, ax_hs = 0, other_v = 0, both = 0, n_ready = 0, n_last = 0;
        int last_at = -1, src = 0, cidx = 0, w_beats = 0, n_wlast = 0, wlast_at = -1;
        int bad_wlast = 0, b_at = 0, stray = 0, stall_bad = 0, bad_last = 0, wid_bad = 0;
        int done = 0, ax_done = 0, w_done = 0, errs = 0, serrs = 0;
        logic [31:0] ax_addr = '0;
        logic [3:0]  ax_len = '0, ax_id = '0;
        logic [2:0]  ax_size = '0;
        logic [1:0]  ax_burst = '0;

        for (int i = 0; i < n_beats; i++) begin
            data_q.push_back($urandom);
            strb_q.push_back(4'($urandom_range(0, 15)));
        end
        creq_valid = 1'b1; creq_is_write = wr; creq_addr = addr; creq_len = len; creq_size = size;
        creq_data = wr ? data_q[0] : '0;
        creq_strobe = wr ? strb_q[0] : 4'hF;

        for (int cyc = 0; cyc < 400 && done == 0; cyc++) begin
            arready = (cyc >= stall) && pick(mode, cyc);
            awready = (cyc >= stall) && pick(mode, cyc);
            rvalid  = (ax_done != 0) && !wr && (src < n_beats) && pick(mode, cyc);
            rdata   = rvalid ? data_q[src] : $urandom;
            rlast   = rvalid && (src == n_beats - 1);
            rresp   = 2'($urandom_range(0, 3));
            rid     = 4'($urandom_range(0, 15));
            wready  = pick(mode, cyc + 1);
            bvalid  = (w_done != 0) && (cyc >= b_at);
            bresp   = 2'($urandom_range(0, 3));
            bid     = 4'($urandom_range(0, 15));
            if (wr && cidx < n_beats) begin
                creq_data   = data_q[cidx];
                creq_strobe = strb_q[cidx];
            end
            @(negedge clk);
            if (arvalid && awvalid) both++;
            if (wr ? arvalid : awvalid) other_v++;
            if (cyc >= 1 && cyc < stall &&
                (!(wr ? awvalid : arvalid) || (wr ? awaddr : araddr) != addr || cresp_ready))
                stall_bad++;
            if ((wr ? awvalid : arvalid) && first_v < 0) first_v = cyc;
            if (wr ? (awvalid && awready) : (arvalid && arready)) begin
                ax_hs++; ax_done = 1;
                ax_addr  = wr ? awaddr : araddr;
                ax_len   = wr ? awlen : arlen;
                ax_size  = wr ? awsize : arsize;
                ax_burst = wr ? awburst : arburst;
                ax_id    = wr ? awid : arid;
            end
            if (cresp_ready) n_ready++;
            if (!wr && cresp_ready) got_q.push_back(cresp_data);
            if (cresp_data != 0 && !(cresp_ready && !wr)) stray++;
            if (wvalid && wlast && w_beats != n_beats - 1) bad_wlast++;
            if (wvalid && wready) begin
                wd_q.push_back(wdata);
                ws_q.push_back(wstrb);
                if (wid != ID) wid_bad++;
                if (wlast) begin
                    n_wlast++; wlast_at = w_beats; w_done = 1;
                    b_at = cyc + (mode == 0 ? 1 : mode == 1 ? 3 : int'($urandom_range(1, 4)));
                end
                w_beats++;
            end
            if (cresp_last) begin
                n_last++; last_at = n_ready; done = 1;
                if (wr && !(bvalid && bready)) bad_last++;
            end
            if (wr && cresp_ready && !cresp_last) cidx++;
            if (rvalid && rready) src++;
            @(posedge clk); #1;
        end
        slave_idle();

        check({tag, " done"}, done, 1);
        check({tag, " addr latency"}, first_v, 1);
        check({tag, " addr handshakes"}, ax_hs, 1);
        check({tag, " ax_addr"}, ax_addr, addr);
        check({tag, " ax_len"}, 32'(ax_len), 32'(len));
        check({tag, " ax_size"}, 32'(ax_size), 32'(size));
        check({tag, " ax_burst"}, 32'(ax_burst), 32'd1);
        check({tag, " ax_id"}, 32'(ax_id), 32'(ID));
        check({tag, " other channel valid"}, other_v + both, 0);
        check({tag, " ready pulses"}, n_ready, exp_beats);
        check({tag, " last count"}, n_last, 1);
        check({tag, " last position"}, last_at, exp_beats);
        check({tag, " stray cresp data"}, stray, 0);
        check({tag, " stall stability"}, stall_bad, 0);
        if (wr) begin
            for (int i = 0; i < n_beats && i < wd_q.size(); i++) begin
                if (wd_q[i] !== data_q[i]) errs++;
                if (ws_q[i] !== strb_q[i]) serrs++;
            end
            check({tag, " w beats"}, w_beats, exp_beats);
            check({tag, " wdata errs"}, errs, 0);
            check({tag, " wstrb errs"}, serrs, 0);
            check({tag, " wlast count"}, n_wlast, 1);
            check({tag, " wlast position"}, wlast_at, exp_beats - 1);
            check({tag, " wlast early"}, bad_wlast, 0);
            check({tag, " last without b"}, bad_last, 0);
            check({tag, " wid"}, wid_bad, 0);
        end else begin
            for (int i = 0; i < n_beats && i < got_q.size(); i++)
                if (got_q[i] !== data_q[i]) errs++;
            check({tag, " r beats"}, got_q.size(), exp_beats);
            check({tag, " rdata order errs"}, errs, 0);
        end

        if (!keep_valid) begin
            creq_valid = 1'b0;
            @(negedge clk);
            check({tag, " idle after"}, 32'({arvalid, awvalid, cresp_ready, cresp_last}), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        int          mode;
        int          stall;
        bit          keep;
        int          exp_beats;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 32'h1000_0004, 4'd0,  3'd2, 0, 0,  0, 1};
        vecs[1] = '{0, 32'h8000_0040, 4'd3,  3'd2, 1, 0,  0, 4};
        vecs[2] = '{1, 32'h8000_0040, 4'd3,  3'd2, 1, 0,  0, 4};
        vecs[3] = '{1, 32'h0000_0100, 4'd0,  3'd2, 0, 0,  1, 1};
        vecs[4] = '{0, 32'h0000_0200, 4'd3,  3'd2, 0, 0,  0, 4};
        vecs[5] = '{0, 32'h2000_0010, 4'd1,  3'd2, 0, 11, 0, 2};
        vecs[6] = '{1, 32'hFFFF_FFC0, 4'd15, 3'd2, 2, 0,  0, 16};
        vecs[7] = '{0, 32'h0000_0000, 4'd15, 3'd1, 2, 0,  0, 16};

        creq_valid = 1'b0; creq_is_write = 1'b0; creq_size = '0; creq_addr = '0;
        creq_strobe = '0; creq_data = 32'hA5A5_A5A5; creq_len = '0;
        slave_idle();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].size,
                    vecs[i].mode, vecs[i].stall, vecs[i].keep, vecs[i].exp_beats);

        for (int i = 0; i < 30; i++) begin
            logic [3:0] len;
            len = 4'($urandom_range(0, 15));
            run_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, len,
                    3'($urandom_range(0, 2)), 2, int'($urandom_range(0, 3)),
                    (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0, int'(len) + 1);
        end

        // Reset in the middle of the second beat of a 4-beat read.
        creq_valid = 1'b1; creq_is_write = 1'b0; creq_addr = 32'h4000_0000;
        creq_len = 4'd3; creq_size = 3'd2; arready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rvalid = 1'b1; rdata = 32'h1111_1111; rlast = 1'b0;
        @(posedge clk); #1;
        rdata = 32'h2222_2222;
        #2;
        check("rst pre ready", 32'(cresp_ready), 32'd1);
        check("rst pre data", cresp_data, 32'h2222_2222);
        resetn = 1'b0;
        #1 check_zero("rst async");
        creq_valid = 1'b0;
        slave_idle();
        @(posedge clk); #1;
        check_zero("rst held");
        resetn = 1'b1;
        run_txn("post-rst", 1'b0, 32'h1000_0004, 4'd0, 3'd2, 0, 0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
